fp_multiplier_param: RTL and testbench

Parametrised, iterative IEEE-754-style floating-point multiplier for the floating-point ALU. It generalises the single-precision multiplier to any exponent and mantissa width, and computes the significand product with a multi-cycle shift-add datapath. It adds round-to-nearest-even, signed zeros, NaN handling and an inexact/invalid flag set. It sits beside the existing adder and multiplier units behind the same start/done style of handshake.

---
 rtl/fp_multiplier_param.sv | 183 ++++++++++++++++++
 tb/tb_fp_multiplier_param.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_multiplier_param.sv
// Parametrised iterative floating-point multiplier. It computes the significand product
// by shift-add, then normalises and rounds to nearest-even in a single cycle.
module fp_multiplier_param #(
  parameter int EXP_W          = 8,
  parameter int MAN_W          = 23,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   busy,
  output logic                   done,
  output logic [EXP_W+MAN_W:0]   result,
  output logic                   overflow,
  output logic                   underflow,
  output logic                   inexact,
  output logic                   invalid
);

  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int SW   = MAN_W + 1;
  localparam int PW   = 2 * SW;
  localparam int N    = SW / BITS_PER_CYCLE;
  localparam int CW   = $clog2(N) + 1;
  localparam int EW2  = EXP_W + 2;
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam int EMAX = (1 << EXP_W) - 1;

  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MULT, NORM, DONE} state_t;

  state_t state, state_next;

  logic [W-1:0]  a_q, b_q;
  logic [PW-1:0] acc, acc_next, mcand;
  logic [SW-1:0] mplier;
  logic [CW-1:0] cnt;

  logic [W-1:0]  norm_res;
  logic          norm_ov, norm_un, norm_inx, norm_inv;

  // Zero or all-ones exponent: operand takes the special path and skips MULT.
  function automatic logic is_special(input logic [W-1:0] x);
    return (x[W-2:MAN_W] == '0) || (&x[W-2:MAN_W]);
  endfunction

  // NOTE: sequential state is written only with non-blocking assignments.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    state_next = IDLE;
    case (state)
      IDLE:    state_next = start ? ((is_special(a) || is_special(b)) ? NORM : MULT) : IDLE;
      MULT:    state_next = (cnt == '0) ? NORM : MULT;
      NORM:    state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  // NOTE: datapath registers carry no reset; control state alone decides what is live.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      a_q    <= a;
      b_q    <= b;
      acc    <= '0;
      mcand  <= {{SW{1'b0}}, 1'b1, a[MAN_W-1:0]};
      mplier <= {1'b1, b[MAN_W-1:0]};
      cnt    <= CW'(N - 1);
    end else if (state == MULT) begin
      acc    <= acc_next;
      mcand  <= mcand << BITS_PER_CYCLE;
      mplier <= mplier >> BITS_PER_CYCLE;
      cnt    <= cnt - 1'b1;
    end
  end

  always_comb begin
    acc_next = acc;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (mplier[i]) acc_next = acc_next + (mcand << i);
    end
  end

  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic             sign, msb, guard, sticky, round_up, carry;
  logic [PW-2:0]    pn;
  logic [MAN_W-1:0] frac, frac_r;
  logic [EW2-1:0]   e_u;
  logic             nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;

  assign ea   = a_q[W-2:MAN_W];
  assign eb   = b_q[W-2:MAN_W];
  assign fa   = a_q[MAN_W-1:0];
  assign fb   = b_q[MAN_W-1:0];
  assign sign = a_q[W-1] ^ b_q[W-1];

  assign nan_a  = (&ea) && (|fa);
  assign nan_b  = (&eb) && (|fb);
  assign inf_a  = (&ea) && !(|fa);
  assign inf_b  = (&eb) && !(|fb);
  assign zero_a = (ea == '0);
  assign zero_b = (eb == '0);

  always_comb begin
    msb      = acc[PW-1];
    // Left-align the product so the hidden one sits just above the kept fraction.
    pn       = msb ? acc[PW-2:0] : {acc[PW-3:0], 1'b0};
    frac     = pn[PW-2 -: MAN_W];
    guard    = pn[PW-2-MAN_W];
    sticky   = |pn[PW-3-MAN_W:0];
    round_up = guard & (sticky | frac[0]);
    {carry, frac_r} = {1'b0, frac} + {{MAN_W{1'b0}}, round_up};
    e_u = {2'b00, ea} + {2'b00, eb} - EW2'(BIAS)
        + {{(EW2-1){1'b0}}, msb} + {{(EW2-1){1'b0}}, carry};

    norm_res = {sign, e_u[EXP_W-1:0], frac_r};
    norm_ov  = 1'b0;
    norm_un  = 1'b0;
    norm_inx = guard | sticky;
    norm_inv = 1'b0;

    if (!e_u[EW2-1] && e_u >= EW2'(EMAX)) begin
      norm_res = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      norm_ov  = 1'b1;
      norm_inx = 1'b1;
    end else if (e_u[EW2-1] || e_u == '0) begin
      norm_res = {sign, {(W-1){1'b0}}};
      norm_un  = 1'b1;
      norm_inx = 1'b1;
    end

    if (nan_a || nan_b) begin
      norm_res = QNAN;
      norm_ov = 1'b0; norm_un = 1'b0; norm_inx = 1'b0;
    end else if ((zero_a && inf_b) || (inf_a && zero_b)) begin
      norm_res = QNAN;
      norm_ov = 1'b0; norm_un = 1'b0; norm_inx = 1'b0; norm_inv = 1'b1;
    end else if (inf_a || inf_b) begin
      norm_res = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      norm_ov = 1'b0; norm_un = 1'b0; norm_inx = 1'b0;
    end else if (zero_a || zero_b) begin
      norm_res = {sign, {(W-1){1'b0}}};
      norm_ov = 1'b0; norm_un = 1'b0; norm_inx = 1'b0;
    end
  end

  // Flags clear on acceptance; the result holds until NORM overwrites it.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      result    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      inexact   <= 1'b0;
      invalid   <= 1'b0;
    end else if (state == IDLE && start) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
      inexact   <= 1'b0;
      invalid   <= 1'b0;
    end else if (state == NORM) begin
      result    <= norm_res;
      overflow  <= norm_ov;
      underflow <= norm_un;
      inexact   <= norm_inx;
      invalid   <= norm_inv;
    end
  end

endmodule

// File: tb/tb_fp_multiplier_param.sv
// Bench for fp_multiplier_param. It runs single precision and a 5/10 half-precision
// instance against a real-arithmetic reference model.
module tb_fp_multiplier_param;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flg;   // {overflow, underflow, inexact, invalid}
    int          lat;
  } exp_t;

  typedef struct {
    int          g;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] res;
    logic [3:0]  flg;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  start, busy, done, ovf, unf, inx, inv;
  logic [31:0] opa [2];
  logic [31:0] opb [2];
  logic [31:0] res [2];
  logic [31:0] r0;
  logic [15:0] r1;
  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fp_multiplier_param dut0 (
    .clk(clk), .reset_n(reset_n), .start(start[0]), .a(opa[0]), .b(opb[0]),
    .busy(busy[0]), .done(done[0]), .result(r0), .overflow(ovf[0]),
    .underflow(unf[0]), .inexact(inx[0]), .invalid(inv[0])
  );

  fp_multiplier_param #(.EXP_W(5), .MAN_W(10), .BITS_PER_CYCLE(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start[1]), .a(opa[1][15:0]), .b(opb[1][15:0]),
    .busy(busy[1]), .done(done[1]), .result(r1), .overflow(ovf[1]),
    .underflow(unf[1]), .inexact(inx[1]), .invalid(inv[1])
  );

  assign res[0] = r0;
  assign res[1] = {16'h0000, r1};

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Reference: exact integer product, then round the real value to MW fraction bits.
  function automatic exp_t model(input int ew, input int mw, input logic [31:0] x, input logic [31:0] y);
    exp_t   r;
    longint emax, bias, ex, ey, fx, fy, p, q, rem, half, e, qnan, sgn, msb;
    int     sh;
    emax = (longint'(1) << ew) - 1;
    bias = (longint'(1) << (ew - 1)) - 1;
    ex   = (longint'(x) >> mw) & emax;
    ey   = (longint'(y) >> mw) & emax;
    fx   = longint'(x) & ((longint'(1) << mw) - 1);
    fy   = longint'(y) & ((longint'(1) << mw) - 1);
    sgn  = longint'(x[ew+mw] ^ y[ew+mw]) << (ew + mw);
    qnan = (emax << mw) | (longint'(1) << (mw - 1));
    r.res = '0; r.flg = '0; r.lat = 2;
    if ((ex == emax && fx != 0) || (ey == emax && fy != 0)) begin
      r.res = 32'(qnan);
    end else if ((ex == 0 && ey == emax) || (ex == emax && ey == 0)) begin
      r.res = 32'(qnan); r.flg = 4'b0001;
    end else if (ex == emax || ey == emax) begin
      r.res = 32'(sgn | (emax << mw));
    end else if (ex == 0 || ey == 0) begin
      r.res = 32'(sgn);
    end else begin
      r.lat = mw + 3;
      p    = ((longint'(1) << mw) | fx) * ((longint'(1) << mw) | fy);
      msb  = (p >= (longint'(1) << (2 * mw + 1))) ? 1 : 0;
      sh   = mw + int'(msb);
      q    = p >> sh;
      rem  = p & ((longint'(1) << sh) - 1);
      half = longint'(1) << (sh - 1);
      e    = ex + ey - bias + msb;
      if (rem > half || (rem == half && q[0])) q++;
      if (q == (longint'(1) << (mw + 1))) begin
        q = q >> 1;
        e++;
      end
      if (e >= emax) begin
        r.res = 32'(sgn | (emax << mw)); r.flg = 4'b1010;
      end else if (e <= 0) begin
        r.res = 32'(sgn); r.flg = 4'b0110;
      end else begin
        r.res = 32'(sgn | (e << mw) | (q - (longint'(1) << mw)));
        r.flg = {2'b00, rem != 0, 1'b0};
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] rand_op(input int ew, input int mw);
    longint emax, bias, e, f, s;
    emax = (longint'(1) << ew) - 1;
    bias = (longint'(1) << (ew - 1)) - 1;
    f    = longint'($urandom) & ((longint'(1) << mw) - 1);
    s    = longint'($urandom_range(0, 1));
    case ($urandom_range(0, 11))
      0:       e = 0;
      1:       begin e = emax; f = 0; end
      2:       begin e = emax; f = f | 1; end
      3:       e = emax - 1 - longint'($urandom_range(0, 3));
      4:       e = 1 + longint'($urandom_range(0, 3));
      5:       begin e = bias; f = longint'($urandom_range(0, 3)); end
      6, 7:    e = bias - 2 + longint'($urandom_range(0, 4));
      default: e = longint'($urandom_range(1, 32'(emax - 1)));
    endcase
    return 32'((s << (ew + mw)) | (e << mw) | f);
  endfunction

  // One scoreboard per instance: expectation queued at acceptance, compared at done.
  for (genvar g = 0; g < 2; g++) begin : g_mon
    localparam int EW = (g == 0) ? 8 : 5;
    localparam int MW = (g == 0) ? 23 : 10;
    exp_t q_exp [$];
    int   q_cyc [$];
    exp_t e;
    int   ac;

    always @(posedge clk) begin
      if (!reset_n) begin
        q_exp.delete();
        q_cyc.delete();
      end else if (start[g] && !busy[g]) begin
        q_exp.push_back(model(EW, MW, opa[g], opb[g]));
        q_cyc.push_back(cyc);
      end
    end

    always @(negedge clk) begin
      if (reset_n && done[g]) begin
        if (q_exp.size() == 0) begin
          check($sformatf("unexpected_done%0d", g), 64'(done[g]), 64'(0));
        end else begin
          e  = q_exp.pop_front();
          ac = q_cyc.pop_front();
          check($sformatf("result%0d", g), 64'(res[g]), 64'(e.res));
          check($sformatf("flags%0d", g), 64'({ovf[g], unf[g], inx[g], inv[g]}), 64'(e.flg));
          check($sformatf("latency%0d", g), 64'(cyc - ac), 64'(e.lat));
        end
      end
    end
  end

  task automatic run_op(input int g, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] r, output logic [3:0] f);
    @(negedge clk);
    opa[g] = x; opb[g] = y; start[g] = 1'b1;
    @(negedge clk);
    start[g] = 1'b0;
    for (int k = 0; k < 100 && !done[g]; k++) @(negedge clk);
    check($sformatf("done_seen%0d", g), 64'(done[g]), 64'(1));
    r = res[g];
    f = {ovf[g], unf[g], inx[g], inv[g]};
    @(negedge clk);
  endtask

  vec_t dir [12] = '{
    '{0, 32'h40400000, 32'h40000000, 32'h40C00000, 4'b0000},
    '{0, 32'hC0000000, 32'h40400000, 32'hC0C00000, 4'b0000},
    '{0, 32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0010},
    '{0, 32'h3FC00000, 32'h3FC00000, 32'h40100000, 4'b0000},
    '{0, 32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b1010},
    '{0, 32'h00800000, 32'h00800000, 32'h00000000, 4'b0110},
    '{0, 32'h80800000, 32'h00800000, 32'h80000000, 4'b0110},
    '{0, 32'h00000000, 32'h7F800000, 32'h7FC00000, 4'b0001},
    '{0, 32'h7FA00000, 32'h3F800000, 32'h7FC00000, 4'b0000},
    '{0, 32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000},
    '{1, 32'h00004200, 32'h00004000, 32'h00004600, 4'b0000},
    '{1, 32'h00007800, 32'h00007800, 32'h00007C00, 4'b1010}
  };

  initial begin
    logic [31:0] r;
    logic [3:0]  f;
    exp_t        m;
    int          nd;
    int          td [3];

    reset_n = 1'b0;
    start   = '0;
    opa[0] = '0; opb[0] = '0; opa[1] = '0; opb[1] = '0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check($sformatf("rst_result%0d", g), 64'(res[g]), 64'(0));
      check($sformatf("rst_busy%0d", g), 64'(busy[g]), 64'(0));
      check($sformatf("rst_done%0d", g), 64'(done[g]), 64'(0));
      check($sformatf("rst_flags%0d", g), 64'({ovf[g], unf[g], inx[g], inv[g]}), 64'(0));
    end
    reset_n = 1'b1;

    // The literal expectations pin both the model and the DUT.
    foreach (dir[i]) begin
      m = model((dir[i].g == 0) ? 8 : 5, (dir[i].g == 0) ? 23 : 10, dir[i].x, dir[i].y);
      check($sformatf("model_pin_res[%0d]", i), 64'(m.res), 64'(dir[i].res));
      check($sformatf("model_pin_flg[%0d]", i), 64'(m.flg), 64'(dir[i].flg));
      run_op(dir[i].g, dir[i].x, dir[i].y, r, f);
      check($sformatf("dir_res[%0d]", i), 64'(r), 64'(dir[i].res));
      check($sformatf("dir_flg[%0d]", i), 64'(f), 64'(dir[i].flg));
    end

    // A start pulse during MULT, carrying different operands, must be ignored.
    @(negedge clk);
    opa[0] = 32'h40400000; opb[0] = 32'h40000000; start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (4) @(negedge clk);
    opa[0] = 32'h3F800001; opb[0] = 32'h3FC00000; start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    for (int k = 0; k < 100 && !done[0]; k++) @(negedge clk);
    check("ignored_start_done", 64'(done[0]), 64'(1));
    check("ignored_start_res", 64'(res[0]), 64'h40C00000);
    @(negedge clk);

    // Holding start high gives back-to-back operations.
    @(negedge clk);
    opa[0] = 32'h40400000; opb[0] = 32'h40000000; start[0] = 1'b1;
    nd = 0; td = '{0, 0, 0};
    for (int k = 0; k < 200 && nd < 3; k++) begin
      @(negedge clk);
      if (done[0]) begin
        td[nd] = cyc;
        nd++;
      end
    end
    start[0] = 1'b0;
    check("b2b_count", 64'(nd), 64'(3));
    check("b2b_gap1", 64'(td[1] - td[0]), 64'(27));
    check("b2b_gap2", 64'(td[2] - td[1]), 64'(27));
    for (int k = 0; k < 100 && busy[0]; k++) @(negedge clk);

    // Reset in MULT cycle 10 aborts without a done pulse.
    @(negedge clk);
    opa[0] = 32'h3FC00000; opb[0] = 32'h40400000; start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (9) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("abort_busy", 64'(busy[0]), 64'(0));
    check("abort_done", 64'(done[0]), 64'(0));
    check("abort_result", 64'(res[0]), 64'(0));
    check("abort_flags", 64'({ovf[0], unf[0], inx[0], inv[0]}), 64'(0));
    reset_n = 1'b1;
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (done[0]) nd++;
    end
    check("abort_no_done", 64'(nd), 64'(0));

    for (int n = 0; n < 250; n++) run_op(0, rand_op(8, 23), rand_op(8, 23), r, f);
    for (int n = 0; n < 120; n++) run_op(1, rand_op(5, 10), rand_op(5, 10), r, f);

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
